// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle control FSM for an RV32I core.
// Sequences ALU, memory port, IR, PC and register file from the decoded
// opcode/funct fields. Outputs are Moore-decoded from the state, with the
// memory-handshake qualifiers gated by mem_ready, and forced to 0 while rst is high.
// Optional build macro RISCV_MC_ILLEGAL_TRAP_EN: illegal instructions enter a
// sticky TRAP state instead of being retired as NOPs.
module riscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7_rest,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] alu_ctrl,
  output logic       mem_timeout,
  output logic [3:0] state_o
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // alu_ops_t encoding shared with the ALU
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_LUI = 4'd12, S_AUIPC = 4'd13, S_TRAP = 4'd14
  } state_t;

  state_t        state_q, state_d;
  logic          sub_q, sub_d;      // JALR substep: 0 = target calc, 1 = PC/rd update
  logic [CW-1:0] cnt_q, cnt_d;      // memory wait counter
  logic          tmo_hit;

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic is_r,
                                         input logic f7b5);
    case (f3)
      F3_ADD_SUB: alu_map = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      F3_SLT:     alu_map = ALU_SLT;
      F3_XOR:     alu_map = ALU_XOR;
      F3_OR:      alu_map = ALU_OR;
      F3_AND:     alu_map = ALU_AND;
      default:    alu_map = ALU_ADD;
    endcase
  endfunction

  // funct3 values the ALU has no operation for
  function automatic logic alu_f3_bad(input logic [2:0] f3);
    alu_f3_bad = (f3 == F3_SLL) || (f3 == F3_SLTU) || (f3 == F3_SRL_SRA);
  endfunction

  function automatic logic is_illegal(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7b5, input logic f7rest);
    case (op)
      OP_LOAD:   is_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OP_STORE:  is_illegal = (f3 > 3'b010);
      OP_R:      is_illegal = alu_f3_bad(f3) || f7rest || (f7b5 && (f3 != F3_ADD_SUB));
      OP_I:      is_illegal = alu_f3_bad(f3);
      OP_BRANCH: is_illegal = (f3 == 3'b010) || (f3 == 3'b011);
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_illegal = 1'b0;
      default:   is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic zero,
                                    input logic lt, input logic ltu);
    case (f3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = !zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  endfunction

  // A timeout of 0 disables the abort path entirely
  assign tmo_hit = (MEM_TIMEOUT > 0) && (cnt_q == CW'(MEM_TIMEOUT));

  // State, JALR substep and wait-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      sub_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore/qualified output decode
  always_comb begin
    state_d     = state_q;
    sub_d       = 1'b0;
    cnt_d       = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    imm_src     = 3'd0;
    result_src  = 2'd0;
    alu_ctrl    = ALU_ADD;
    mem_timeout = 1'b0;
    state_o     = 4'd0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_hit) begin
          mem_req     = 1'b0;
          mem_timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src   = 3'd2;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FETCH;
        endcase
        if (is_illegal(opcode, funct3, funct7b5, funct7_rest)) begin
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end else begin
          sub_d = 1'b0;
        end
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        imm_src   = (opcode == OP_STORE) ? 3'd1 : 3'd0;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD, S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = (state_q == S_MEMWRITE);
        adr_src = 1'b1;
        if (mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (tmo_hit) begin
          mem_req     = 1'b0;
          mem_we      = 1'b0;
          mem_timeout = 1'b1;
          state_d     = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'd1;
        state_d    = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a = 2'd2;
        alu_src_b = (state_q == S_EXECI) ? 2'd1 : 2'd0;
        alu_ctrl  = alu_map(funct3, (state_q == S_EXECR), funct7b5);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd2;
        alu_ctrl  = ALU_SUB;
        pc_write  = br_taken(funct3, alu_zero, alu_lt, alu_ltu);
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        if (!sub_q) begin
          alu_src_a = 2'd2;
          alu_src_b = 2'd1;
          sub_d     = 1'b1;
        end else begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          pc_write  = 1'b1;
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_LUI, S_AUIPC: begin
        alu_src_a = (state_q == S_LUI) ? 2'd3 : 2'd1;
        alu_src_b = 2'd1;
        imm_src   = 3'd4;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    if (rst) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'd0;
      alu_src_b   = 2'd0;
      imm_src     = 3'd0;
      result_src  = 2'd0;
      alu_ctrl    = ALU_ADD;
      mem_timeout = 1'b0;
      state_o     = 4'd0;
    end else begin
      state_o = state_q;
    end
  end
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed self-checking bench for riscv_mc_ctrl (built with MEM_TIMEOUT=4).
module tb_riscv_mc_ctrl;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5, funct7_rest;
  logic       alu_zero, alu_lt, alu_ltu, mem_ready;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, mem_timeout;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl, state_o;

  int n_checks = 0;
  int n_errs   = 0;

  riscv_mc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .funct7_rest(funct7_rest), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_ctrl(alu_ctrl), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and check the state shown in the new cycle
  task automatic nx(input string tag, input logic [3:0] st);
    @(negedge clk);
    chk4($sformatf("%s.state", tag), state_o, st);
  endtask

  task automatic set_ir(input logic [31:0] ir);
    opcode      = ir[6:0];
    funct3      = ir[14:12];
    funct7b5    = ir[30];
    funct7_rest = ir[31] | (|ir[29:25]);
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0;
    set_ir(32'h00000013);
    repeat (2) @(negedge clk);
    chk4("rst.state", state_o, 4'd0);
    chk1("rst.mem_req", mem_req, 1'b0);
    chk1("rst.pc_write", pc_write, 1'b0);
    chk4("rst.alu_src_b", {2'b00, alu_src_b}, 4'd0);

    // add x3,x1,x2
    set_ir(32'h002081B3); rst = 1'b0; #1;
    chk4("add.f.state", state_o, 4'd0);
    chk1("add.f.mem_req", mem_req, 1'b1);
    chk1("add.f.adr_src", adr_src, 1'b0);
    chk1("add.f.ir_write", ir_write, 1'b1);
    chk1("add.f.pc_write", pc_write, 1'b1);
    chk4("add.f.src_b", {2'b00, alu_src_b}, 4'd2);
    chk4("add.f.result_src", {2'b00, result_src}, 4'd2);
    chk4("add.f.alu", alu_ctrl, ALU_ADD);
    nx("add.dec", 4'd1);
    chk4("add.dec.src_a", {2'b00, alu_src_a}, 4'd1);
    chk4("add.dec.imm_src", {1'b0, imm_src}, 4'd2);
    chk1("add.dec.mem_req", mem_req, 1'b0);
    nx("add.ex", 4'd6);
    chk4("add.ex.alu", alu_ctrl, ALU_ADD);
    chk4("add.ex.src_a", {2'b00, alu_src_a}, 4'd2);
    chk4("add.ex.src_b", {2'b00, alu_src_b}, 4'd0);
    chk1("add.ex.reg_write", reg_write, 1'b0);
    nx("add.wb", 4'd8);
    chk1("add.wb.reg_write", reg_write, 1'b1);
    chk4("add.wb.result_src", {2'b00, result_src}, 4'd0);
    nx("add.next", 4'd0);

    // sub x3,x1,x2
    set_ir(32'h402081B3);
    nx("sub.dec", 4'd1);
    nx("sub.ex", 4'd6);
    chk4("sub.ex.alu", alu_ctrl, ALU_SUB);
    nx("sub.wb", 4'd8);
    nx("sub.next", 4'd0);

    // lw x5,0(x1) with three stall cycles in MEMREAD
    set_ir(32'h0000A283);
    nx("lw.dec", 4'd1);
    nx("lw.adr", 4'd2);
    chk4("lw.adr.src_b", {2'b00, alu_src_b}, 4'd1);
    chk4("lw.adr.imm_src", {1'b0, imm_src}, 4'd0);
    nx("lw.rd1", 4'd3);
    chk1("lw.rd1.mem_req", mem_req, 1'b1);
    chk1("lw.rd1.adr_src", adr_src, 1'b1);
    chk1("lw.rd1.mem_we", mem_we, 1'b0);
    mem_ready = 1'b0;
    nx("lw.rd2", 4'd3);
    nx("lw.rd3", 4'd3);
    chk1("lw.rd3.mem_timeout", mem_timeout, 1'b0);
    nx("lw.rd4", 4'd3);
    mem_ready = 1'b1;
    chk1("lw.rd4.mem_req", mem_req, 1'b1);
    nx("lw.wb", 4'd4);
    chk1("lw.wb.reg_write", reg_write, 1'b1);
    chk4("lw.wb.result_src", {2'b00, result_src}, 4'd1);
    nx("lw.next", 4'd0);

    // sw x5,4(x1)
    set_ir(32'h0050A223);
    nx("sw.dec", 4'd1);
    nx("sw.adr", 4'd2);
    chk4("sw.adr.imm_src", {1'b0, imm_src}, 4'd1);
    nx("sw.wr", 4'd5);
    chk1("sw.wr.mem_req", mem_req, 1'b1);
    chk1("sw.wr.mem_we", mem_we, 1'b1);
    chk1("sw.wr.adr_src", adr_src, 1'b1);
    nx("sw.next", 4'd0);

    // beq taken (zero=1)
    alu_zero = 1'b1; set_ir(32'h00208463);
    nx("beq.dec", 4'd1);
    nx("beq.br", 4'd9);
    chk4("beq.br.alu", alu_ctrl, ALU_SUB);
    chk1("beq.br.pc_write", pc_write, 1'b1);
    nx("beq.next", 4'd0);

    // bne not taken (zero=1)
    set_ir(32'h00209463);
    nx("bne.dec", 4'd1);
    nx("bne.br", 4'd9);
    chk1("bne.br.pc_write", pc_write, 1'b0);
    nx("bne.next", 4'd0);

    // blt taken, then bgeu not taken
    alu_zero = 1'b0; alu_lt = 1'b1; alu_ltu = 1'b1; set_ir(32'h0020C463);
    nx("blt.dec", 4'd1);
    nx("blt.br", 4'd9);
    chk1("blt.br.pc_write", pc_write, 1'b1);
    nx("blt.next", 4'd0);
    set_ir(32'h0020F463);
    nx("bgeu.dec", 4'd1);
    nx("bgeu.br", 4'd9);
    chk1("bgeu.br.pc_write", pc_write, 1'b0);
    nx("bgeu.next", 4'd0);

    // jal x1,8
    set_ir(32'h008000EF);
    nx("jal.dec", 4'd1);
    nx("jal.j", 4'd10);
    chk1("jal.j.pc_write", pc_write, 1'b1);
    chk4("jal.j.src_a", {2'b00, alu_src_a}, 4'd1);
    chk4("jal.j.src_b", {2'b00, alu_src_b}, 4'd2);
    chk1("jal.j.reg_write", reg_write, 1'b0);
    nx("jal.wb", 4'd8);
    chk1("jal.wb.reg_write", reg_write, 1'b1);
    nx("jal.next", 4'd0);

    // jalr x1,0(x1)
    set_ir(32'h000080E7);
    nx("jalr.dec", 4'd1);
    nx("jalr.s0", 4'd11);
    chk1("jalr.s0.pc_write", pc_write, 1'b0);
    chk4("jalr.s0.src_a", {2'b00, alu_src_a}, 4'd2);
    nx("jalr.s1", 4'd11);
    chk1("jalr.s1.pc_write", pc_write, 1'b1);
    chk1("jalr.s1.reg_write", reg_write, 1'b1);
    nx("jalr.next", 4'd0);

    // lui x1,0x12345
    set_ir(32'h123450B7);
    nx("lui.dec", 4'd1);
    nx("lui.u", 4'd12);
    chk4("lui.u.src_a", {2'b00, alu_src_a}, 4'd3);
    chk4("lui.u.imm_src", {1'b0, imm_src}, 4'd4);
    nx("lui.wb", 4'd8);
    nx("lui.next", 4'd0);

    // xori x1,x1,0xff
    set_ir(32'h0FF0C093);
    nx("xori.dec", 4'd1);
    nx("xori.ex", 4'd7);
    chk4("xori.ex.alu", alu_ctrl, ALU_XOR);
    chk4("xori.ex.src_b", {2'b00, alu_src_b}, 4'd1);
    nx("xori.wb", 4'd8);
    nx("xori.next", 4'd0);

    // fetch timeout: ready low from FETCH cycle 1, abort in cycle 5
    set_ir(32'h002081B3); mem_ready = 1'b0;
    chk1("tmo.c1.mem_timeout", mem_timeout, 1'b0);
    nx("tmo.c2", 4'd0);
    chk1("tmo.c2.mem_req", mem_req, 1'b1);
    nx("tmo.c3", 4'd0);
    nx("tmo.c4", 4'd0);
    chk1("tmo.c4.mem_timeout", mem_timeout, 1'b0);
    nx("tmo.c5", 4'd0);
    chk1("tmo.c5.mem_timeout", mem_timeout, 1'b1);
    chk1("tmo.c5.mem_req", mem_req, 1'b0);
    chk1("tmo.c5.pc_write", pc_write, 1'b0);
    nx("tmo.c6", 4'd0);
    chk1("tmo.c6.mem_timeout", mem_timeout, 1'b0);
    chk1("tmo.c6.mem_req", mem_req, 1'b1);
    mem_ready = 1'b1;
    nx("tmo.dec", 4'd1);
    nx("tmo.ex", 4'd6);
    nx("tmo.wb", 4'd8);
    nx("tmo.next", 4'd0);

    // reset asserted in the middle of a MEMWRITE stall
    set_ir(32'h0050A223);
    nx("rsw.dec", 4'd1);
    nx("rsw.adr", 4'd2);
    nx("rsw.wr", 4'd5);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk4("rsw.rst.state", state_o, 4'd0);
    chk1("rsw.rst.mem_req", mem_req, 1'b0);
    chk1("rsw.rst.mem_we", mem_we, 1'b0);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1; #1;
    chk4("rsw.rel.state", state_o, 4'd0);
    chk1("rsw.rel.mem_req", mem_req, 1'b1);
    chk1("rsw.rel.mem_we", mem_we, 1'b0);
    nx("rsw.dec2", 4'd1);
    nx("rsw.adr2", 4'd2);
    nx("rsw.wr2", 4'd5);
    nx("rsw.next", 4'd0);

    // illegal opcode 0x7F
    set_ir(32'h0000007F);
    nx("ill.dec", 4'd1);
    chk1("ill.dec.reg_write", reg_write, 1'b0);
`ifdef RISCV_MC_ILLEGAL_TRAP_EN
    nx("ill.trap1", 4'd14);
    chk1("ill.trap1.mem_req", mem_req, 1'b0);
    chk1("ill.trap1.pc_write", pc_write, 1'b0);
    nx("ill.trap2", 4'd14);
    nx("ill.trap3", 4'd14);
    chk1("ill.trap3.reg_write", reg_write, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    chk4("ill.rel.state", state_o, 4'd0);
    chk1("ill.rel.mem_req", mem_req, 1'b1);
`else
    nx("ill.next", 4'd0);
    chk1("ill.next.reg_write", reg_write, 1'b0);
    chk1("ill.next.mem_req", mem_req, 1'b1);
    nx("ill.dec2", 4'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
